// File: rtl/bus_arb_pkg.sv
// Shared types and encodings for the four-requester bus arbiter.
package bus_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int unsigned NUM_REQ = 4;

  // These match the mux_4x1 S encoding.
  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

  function automatic logic [3:0] onehot2(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/bus_arbiter_4_rr_pick4.sv
// Rotating priority picker: first set request bit at or after start, wrapping 3->0.
module rr_pick4
  import bus_arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] start,
  output logic       found,
  output logic [1:0] idx
);

  logic [1:0] j;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = start + 2'(i);
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/mux_4x1.sv
// 4:1 word multiplexer; S selects A/B/C/D.
module mux_4x1
  import bus_arb_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic [1:0]       S,
  output logic [WIDTH-1:0] Y
);

  always_comb begin
    Y = A;
    case (S)
      SEL_A:   Y = A;
      SEL_B:   Y = B;
      SEL_C:   Y = C;
      SEL_D:   Y = D;
      default: Y = A;
    endcase
  end

endmodule

// File: rtl/bus_arbiter_4.sv
// Round-robin arbiter for four requesters sharing one select path, with bounded
// bursts and a registered output word.
module bus_arbiter_4
  import bus_arb_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] din_a,
  input  logic [WIDTH-1:0] din_b,
  input  logic [WIDTH-1:0] din_c,
  input  logic [WIDTH-1:0] din_d,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             busy
);

  state_t           state, state_n;
  logic [3:0]       gnt_n;
  logic [1:0]       sel_n;
  logic [1:0]       ptr, ptr_n;
  logic [3:0]       hold_cnt, hold_n;
  logic [1:0]       pick_start;
  logic             found;
  logic [1:0]       win;
  logic             beat;
  logic [WIDTH-1:0] mux_y;

  assign beat = |(gnt & req);
  assign busy = (state == GRANT);

  // In GRANT the re-pick always starts just past the owner, which is what ptr
  // becomes at that same edge; in IDLE it starts at the stored ptr.
  assign pick_start = (state == GRANT) ? sel + 2'd1 : ptr;

  rr_pick4 u_pick (
    .req   (req),
    .start (pick_start),
    .found (found),
    .idx   (win)
  );

  mux_4x1 #(.WIDTH(WIDTH)) u_mux (
    .A (din_a),
    .B (din_b),
    .C (din_c),
    .D (din_d),
    .S (sel),
    .Y (mux_y)
  );

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    sel_n   = sel;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    case (state)
      IDLE: begin
        gnt_n = '0;
        if (found) begin
          state_n = GRANT;
          gnt_n   = onehot2(win);
          sel_n   = win;
          hold_n  = '0;
        end
      end
      GRANT: begin
        if (beat && hold_cnt < 4'(MAX_HOLD - 1)) begin
          hold_n = hold_cnt + 4'd1;
        end else begin
          ptr_n  = sel + 2'd1;
          hold_n = '0;
          if (found) begin
            gnt_n = onehot2(win);
            sel_n = win;
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= SEL_A;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      sel      <= sel_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= beat;
      if (beat) dout <= mux_y;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_4.sv
// Directed bench for bus_arbiter_4: outputs checked on the falling edge, inputs
// changed right after.
module tb_bus_arbiter_4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] din_a, din_b, din_c, din_d;
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic [15:0] dout;
  logic        dout_valid;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] dat [4];
  logic [3:0]  oh;

  always #5 clk = ~clk;

  bus_arbiter_4 #(.WIDTH(16), .MAX_HOLD(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .din_a      (din_a),
    .din_b      (din_b),
    .din_c      (din_c),
    .din_d      (din_d),
    .gnt        (gnt),
    .sel        (sel),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, ".gnt"},   32'(gnt),        32'h0);
    chk({tag, ".sel"},   32'(sel),        32'h0);
    chk({tag, ".dout"},  32'(dout),       32'h0);
    chk({tag, ".valid"}, 32'(dout_valid), 32'h0);
    chk({tag, ".busy"},  32'(busy),       32'h0);
  endtask

  // Reset across one full cycle, released at a falling edge.
  task automatic do_reset();
    req   = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    din_a = 16'haaaa;
    din_b = 16'hbbbb;
    din_c = 16'hcccc;
    din_d = 16'hdddd;
    dat[0] = 16'haaaa; dat[1] = 16'hbbbb; dat[2] = 16'hcccc; dat[3] = 16'hdddd;

    #2;
    chk_idle_reset("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester B, three beats then release.
    req = 4'b0010;
    @(negedge clk);
    chk("t2.gnt1", 32'(gnt), 32'h2);
    chk("t2.sel1", 32'(sel), 32'h1);
    chk("t2.valid1", 32'(dout_valid), 32'h0);
    chk("t2.busy1", 32'(busy), 32'h1);
    din_b = 16'h1111;
    @(negedge clk);
    chk("t2.dout2", 32'(dout), 32'h1111);
    chk("t2.valid2", 32'(dout_valid), 32'h1);
    din_b = 16'h2222;
    @(negedge clk);
    chk("t2.dout3", 32'(dout), 32'h2222);
    din_b = 16'h3333;
    @(negedge clk);
    chk("t2.dout4", 32'(dout), 32'h3333);
    chk("t2.valid4", 32'(dout_valid), 32'h1);
    chk("t2.gnt4", 32'(gnt), 32'h2);
    req = 4'b0000;
    @(negedge clk);
    chk("t2.gnt5", 32'(gnt), 32'h0);
    chk("t2.valid5", 32'(dout_valid), 32'h0);
    chk("t2.dout5", 32'(dout), 32'h3333);
    chk("t2.busy5", 32'(busy), 32'h0);

    // Mid-burst asynchronous reset; ptr was left at 2 by the release above.
    req   = 4'b0010;
    din_b = 16'h1234;
    @(negedge clk);
    chk("t1.gnt", 32'(gnt), 32'h2);
    @(negedge clk);
    chk("t1.dout_pre", 32'(dout), 32'h1234);
    #1 rst_n = 1'b0;
    #2 chk_idle_reset("t1.async");
    #1 rst_n = 1'b1;
    req = 4'b0110;
    @(negedge clk);
    chk("t1.ptr0_gnt", 32'(gnt), 32'h2);
    chk("t1.ptr0_sel", 32'(sel), 32'h1);

    // Full contention: A,B,C,D in turn, four beats each, no bubble.
    do_reset();
    din_b = 16'hbbbb;
    req   = 4'b1111;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      oh = 4'b0001 << (((k - 1) / 4) % 4);
      chk($sformatf("t3.gnt%0d", k), 32'(gnt), 32'(oh));
      chk($sformatf("t3.sel%0d", k), 32'(sel), 32'(((k - 1) / 4) % 4));
      if (k >= 2) begin
        chk($sformatf("t3.valid%0d", k), 32'(dout_valid), 32'h1);
        chk($sformatf("t3.dout%0d", k), 32'(dout), 32'(dat[((k - 2) / 4) % 4]));
      end
    end

    // Early release by A with C and D waiting: C wins, not D.
    do_reset();
    req = 4'b1101;
    @(negedge clk);
    chk("t4.gntA", 32'(gnt), 32'h1);
    @(negedge clk);
    @(negedge clk);
    chk("t4.doutA", 32'(dout), 32'haaaa);
    req = 4'b1100;
    @(negedge clk);
    chk("t4.gntC", 32'(gnt), 32'h4);
    chk("t4.selC", 32'(sel), 32'h2);
    chk("t4.valid_gap", 32'(dout_valid), 32'h0);
    @(negedge clk);
    chk("t4.doutC", 32'(dout), 32'hcccc);
    chk("t4.validC", 32'(dout_valid), 32'h1);

    // Sole requester D: re-granted on expiry with no gap.
    do_reset();
    req = 4'b1000;
    @(negedge clk);
    chk("t5.gnt", 32'(gnt), 32'h8);
    din_d = 16'h0d01;
    for (int k = 2; k <= 14; k++) begin
      @(negedge clk);
      chk($sformatf("t5.gnt%0d", k), 32'(gnt), 32'h8);
      chk($sformatf("t5.valid%0d", k), 32'(dout_valid), 32'h1);
      chk($sformatf("t5.dout%0d", k), 32'(dout), 32'h0d00 + 32'(k - 1));
      din_d = 16'h0d00 + 16'(k);
    end

    // Wrap: D releases (ptr wraps to 0), then A vs D.
    req = 4'b0000;
    @(negedge clk);
    chk("t6.idle", 32'(gnt), 32'h0);
    chk("t6.busy", 32'(busy), 32'h0);
    req = 4'b1001;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("t6.gntA%0d", k), 32'(gnt), 32'h1);
    end
    @(negedge clk);
    chk("t6.gntD", 32'(gnt), 32'h8);
    chk("t6.selD", 32'(sel), 32'h3);
    chk("t6.doutA", 32'(dout), 32'haaaa);
    chk("t6.validA", 32'(dout_valid), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
